// File: rtl/serial_frame_capture_pkg.sv
// Shared state encoding, identification constant and sizing helper for serial_frame_capture.
// The optional parity stage is enabled by defining PARITY_CHK_EN.
package serial_frame_capture_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    PARITY  = 2'd2
  } state_e;

  // Team identification word; the upstream gated-D stage exposes the same value.
  localparam logic [19:0] ID_NUM = 20'h65166;

  function automatic int counterWidth(input int maxVal);
    return (maxVal > 1) ? $clog2(maxVal + 1) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_capture_sync_window_match.sv
// Sliding sync-word window with fill counter; match_o strobes when the word just shifted in completes the sync pattern.
// A flush empties the window so payload bits never take part in the next search.
module sync_window_match
  import serial_frame_capture_pkg::*;
#(
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5
) (
  input  logic clk,
  input  logic clear0,
  input  logic shift_i,
  input  logic bit_i,
  input  logic flush_i,
  output logic match_o
);

  localparam int FILL_W = counterWidth(SYNC_W);

  logic [SYNC_W-1:0] window_q;
  logic [SYNC_W-1:0] window_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;

  // A match is judged on the window as it will be after this bit, and only once it holds SYNC_W real bits.
  always_comb begin
    window_d = {window_q[SYNC_W-2:0], bit_i};
    fill_d   = (fill_q == FILL_W'(SYNC_W)) ? fill_q : fill_q + 1'b1;
    match_o  = shift_i && (window_d == SYNC_PATTERN) && (fill_d == FILL_W'(SYNC_W));
  end

  always_ff @(posedge clk or negedge clear0) begin
    if (!clear0) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (flush_i) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (shift_i) begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/serial_frame_capture.sv
// Serial frame capture: hunts for a sync word, then captures DATA_W payload bits MSB-first and counts frames.
// Define PARITY_CHK_EN to add an even-parity bit after the payload; otherwise parity_err is tied low.
module serial_frame_capture
  import serial_frame_capture_pkg::*;
#(
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                DATA_W       = 8,
  parameter int                CNT_W        = 8
) (
  input  logic              clk,
  input  logic              clear0,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic              sync_found,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy,
  output logic              parity_err,
  output logic [19:0]       id_num
);

  localparam int BC_W = counterWidth(DATA_W - 1);

  state_e            state_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] data_out_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic [CNT_W-1:0]  frame_cnt_d;
  logic              sync_found_q;
  logic              data_valid_q;
  logic              busy_q;
  logic              last_bit;
  logic              match;
  logic              flush;
`ifdef PARITY_CHK_EN
  logic              parity_err_q;
  logic              parity_ok;
`endif

  // Flush the sync window on the edge that ends a frame, whatever its outcome.
  always_comb begin
    shift_d     = (shift_q << 1) | DATA_W'(bit_in);
    last_bit    = (bit_cnt_q == BC_W'(DATA_W - 1));
    frame_cnt_d = (frame_cnt_q == {CNT_W{1'b1}}) ? frame_cnt_q : frame_cnt_q + 1'b1;
`ifdef PARITY_CHK_EN
    parity_ok   = ~((^shift_q) ^ bit_in);
    flush       = bit_en && (state_q == PARITY);
`else
    flush       = bit_en && (state_q == CAPTURE) && last_bit;
`endif
  end

  sync_window_match #(
    .SYNC_W       (SYNC_W),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync_window_match (
    .clk     (clk),
    .clear0  (clear0),
    .shift_i (bit_en && (state_q == HUNT)),
    .bit_i   (bit_in),
    .flush_i (flush),
    .match_o (match)
  );

  // Frame FSM; pulses default low every edge and are raised by the edge sampling the qualifying bit.
  always_ff @(posedge clk or negedge clear0) begin
    if (!clear0) begin
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      frame_cnt_q  <= '0;
      sync_found_q <= 1'b0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PARITY_CHK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_found_q <= 1'b0;
      data_valid_q <= 1'b0;
`ifdef PARITY_CHK_EN
      parity_err_q <= 1'b0;
`endif
      if (bit_en) begin
        case (state_q)
          HUNT: begin
            if (match) begin
              sync_found_q <= 1'b1;
              state_q      <= CAPTURE;
              bit_cnt_q    <= '0;
              busy_q       <= 1'b1;
            end
          end
          CAPTURE: begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
`ifdef PARITY_CHK_EN
              state_q      <= PARITY;
`else
              data_out_q   <= shift_d;
              data_valid_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_d;
              state_q      <= HUNT;
              busy_q       <= 1'b0;
`endif
            end
          end
`ifdef PARITY_CHK_EN
          PARITY: begin
            if (parity_ok) begin
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_d;
            end else begin
              parity_err_q <= 1'b1;
            end
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
`endif
          default: begin
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sync_found = sync_found_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;
  assign id_num     = ID_NUM;
`ifdef PARITY_CHK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_capture.sv
// Self-checking bench for serial_frame_capture: vector table, directed frame sequences and a queue-based reference model.
// Honours PARITY_CHK_EN so the same bench covers both builds.
module tb_serial_frame_capture;

  localparam int         SYNC_W       = 8;
  localparam logic [7:0] SYNC_PATTERN = 8'hA5;
  localparam int         DATA_W       = 8;
  localparam int         CNT_W        = 8;
  localparam int         SAT_CNT_W    = 2;
`ifdef PARITY_CHK_EN
  localparam int         PAR_BITS     = 1;
`else
  localparam int         PAR_BITS     = 0;
`endif

  logic clk    = 1'b0;
  logic clear0 = 1'b0;
  logic bitIn  = 1'b0;
  logic bitEn  = 1'b0;

  logic        syncFound, dataValid, busy, parityErr;
  logic [7:0]  dataOut, frameCnt;
  logic [19:0] idNum;
  logic        satSync, satValid, satBusy, satErr;
  logic [7:0]  satData;
  logic [1:0]  satCnt;
  logic [19:0] satId;

  int assertCount = 0;
  int failCount   = 0;

  bit         mHunting = 1'b1;
  bit         mHist[$];
  bit         mPay[$];
  logic [7:0] mData    = '0;
  int         mCnt     = 0;
  int         mSatCnt  = 0;
  bit         mSync, mValid, mErr, mBusy;

  typedef struct {
    logic       b;
    logic       en;
    logic       expSync;
    logic       expValid;
    logic [7:0] expData;
    logic [7:0] expCnt;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  serial_frame_capture #(
    .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PATTERN), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clear0(clear0), .bit_in(bitIn), .bit_en(bitEn),
    .sync_found(syncFound), .data_out(dataOut), .data_valid(dataValid),
    .frame_cnt(frameCnt), .busy(busy), .parity_err(parityErr), .id_num(idNum)
  );

  serial_frame_capture #(
    .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PATTERN), .DATA_W(DATA_W), .CNT_W(SAT_CNT_W)
  ) dutSat (
    .clk(clk), .clear0(clear0), .bit_in(bitIn), .bit_en(bitEn),
    .sync_found(satSync), .data_out(satData), .data_valid(satValid),
    .frame_cnt(satCnt), .busy(satBusy), .parity_err(satErr), .id_num(satId)
  );

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] queueValue(input bit q[$], input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = (v << 1) | 32'(q[i]);
    return v;
  endfunction

  task automatic modelReset();
    mHunting = 1'b1;
    mHist.delete();
    mPay.delete();
    mData = '0; mCnt = 0; mSatCnt = 0;
    mSync = 1'b0; mValid = 1'b0; mErr = 1'b0; mBusy = 1'b0;
  endtask

  // Reference behaviour: keep the last SYNC_W hunted bits and the collected payload bits as plain lists.
  task automatic modelStep(input logic b, input logic en);
    int ones;
    mSync = 1'b0; mValid = 1'b0; mErr = 1'b0;
    if (en) begin
      if (mHunting) begin
        mHist.push_back(b);
        if (mHist.size() > SYNC_W) void'(mHist.pop_front());
        if (mHist.size() == SYNC_W && queueValue(mHist, SYNC_W) == 32'(SYNC_PATTERN)) begin
          mSync = 1'b1; mHunting = 1'b0; mBusy = 1'b1;
          mPay.delete();
        end
      end else begin
        mPay.push_back(b);
        if (mPay.size() == DATA_W + PAR_BITS) begin
          ones = 0;
          foreach (mPay[i]) ones += int'(mPay[i]);
          if (PAR_BITS == 1 && (ones % 2) == 1) mErr = 1'b1;
          else begin
            mData = 8'(queueValue(mPay, DATA_W));
            mValid = 1'b1;
            if (mCnt < 255) mCnt++;
            if (mSatCnt < 3) mSatCnt++;
          end
          mHunting = 1'b1; mBusy = 1'b0;
          mHist.delete();
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".sync"},   32'(syncFound), 32'(mSync));
    checkValue({tag, ".valid"},  32'(dataValid), 32'(mValid));
    checkValue({tag, ".data"},   32'(dataOut),   32'(mData));
    checkValue({tag, ".cnt"},    32'(frameCnt),  32'(mCnt));
    checkValue({tag, ".busy"},   32'(busy),      32'(mBusy));
    checkValue({tag, ".perr"},   32'(parityErr), 32'(mErr));
    checkValue({tag, ".id"},     32'(idNum),     32'h65166);
    checkValue({tag, ".satCnt"}, 32'(satCnt),    32'(mSatCnt));
    checkValue({tag, ".satData"},32'(satData),   32'(mData));
    checkValue({tag, ".satId"},  32'(satId),     32'h65166);
  endtask

  task automatic applyStimulus(input logic b, input logic en);
    @(negedge clk);
    bitIn = b;
    bitEn = en;
    @(posedge clk);
    #1;
    modelStep(b, en);
    checkOutput("step");
  endtask

  task automatic doReset();
    @(negedge clk);
    clear0 = 1'b0;
    bitEn  = 1'b0;
    #1;
    modelReset();
    checkOutput("resetAsync");
    @(posedge clk);
    #1;
    checkOutput("resetHeld");
    @(negedge clk);
    clear0 = 1'b1;
  endtask

  task automatic sendBits(input logic [31:0] value, input int n, input bit toggle);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(value[i], 1'b1);
      if (toggle) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic sendFrame(input logic [7:0] payload, input bit toggle);
    sendBits(32'(SYNC_PATTERN), SYNC_W, toggle);
    sendBits(32'(payload), DATA_W, toggle);
`ifdef PARITY_CHK_EN
    sendBits(32'(^payload), 1, toggle);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] stream;
    int          lastEdge;
    int          satSeq[5];
    vec_t        v;

    stream   = 16'hA53C;
    lastEdge = 16 + PAR_BITS;
    for (int i = 0; i < lastEdge; i++) begin
      v.b        = (i < 16) ? stream[15 - i] : 1'b0;
      v.en       = 1'b1;
      v.expSync  = (i + 1 == 8);
      v.expValid = (i + 1 == lastEdge);
      v.expData  = (i + 1 >= lastEdge) ? 8'h3C : 8'h00;
      v.expCnt   = (i + 1 >= lastEdge) ? 8'd1 : 8'd0;
      v.expBusy  = (i + 1 >= 8) && (i + 1 < lastEdge);
      vecs.push_back(v);
    end
    satSeq = '{1, 2, 3, 3, 3};

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("powerOnReset");
    @(negedge clk);
    clear0 = 1'b1;

    $display("[TB] continuous frame A5/3C from the vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].b, vecs[i].en);
      checkValue("vec.sync",  32'(syncFound), 32'(vecs[i].expSync));
      checkValue("vec.valid", 32'(dataValid), 32'(vecs[i].expValid));
      checkValue("vec.data",  32'(dataOut),   32'(vecs[i].expData));
      checkValue("vec.cnt",   32'(frameCnt),  32'(vecs[i].expCnt));
      checkValue("vec.busy",  32'(busy),      32'(vecs[i].expBusy));
    end

    $display("[TB] gated frame with garbage on idle cycles");
    doReset();
    sendFrame(8'h3C, 1'b1);
    checkValue("gated.data", 32'(dataOut),  32'h3C);
    checkValue("gated.cnt",  32'(frameCnt), 32'd1);

    $display("[TB] sliding window search");
    doReset();
    sendBits(32'hAA5, 12, 1'b0);
    checkValue("slide.sync", 32'(syncFound), 32'd1);
    checkValue("slide.busy", 32'(busy),      32'd1);
    sendBits(32'hFF, 8, 1'b0);
`ifdef PARITY_CHK_EN
    sendBits(32'd0, 1, 1'b0);
`endif
    checkValue("slide.data", 32'(dataOut), 32'hFF);

    $display("[TB] reset aborts a frame in capture");
    doReset();
    sendBits(32'(SYNC_PATTERN), SYNC_W, 1'b0);
    sendBits(32'hB, 4, 1'b0);
    checkValue("abort.busyBefore", 32'(busy), 32'd1);
    doReset();
    checkValue("abort.busyAfter", 32'(busy),    32'd0);
    checkValue("abort.dataAfter", 32'(dataOut), 32'd0);
    sendFrame(8'h81, 1'b0);
    checkValue("abort.data", 32'(dataOut),  32'h81);
    checkValue("abort.cnt",  32'(frameCnt), 32'd1);

    $display("[TB] frame counter saturation");
    doReset();
    for (int k = 0; k < 5; k++) begin
      sendFrame(8'(8'h13 * (k + 1)), 1'b0);
      checkValue("sat.cnt",  32'(satCnt),   32'(satSeq[k]));
      checkValue("sat.full", 32'(frameCnt), 32'(k + 1));
    end
`ifdef PARITY_CHK_EN
    sendBits(32'(SYNC_PATTERN), SYNC_W, 1'b0);
    sendBits(32'h3C, DATA_W, 1'b0);
    sendBits(32'd1, 1, 1'b0);
    checkValue("parity.err",  32'(parityErr), 32'd1);
    checkValue("parity.cnt",  32'(frameCnt),  32'd5);
    checkValue("parity.hold", 32'(dataOut),   32'(8'h13 * 5));
`endif

    $display("[TB] randomized stream against the reference model");
    doReset();
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = int'($urandom_range(0, 39));
      if (r < 4) sendBits(32'(SYNC_PATTERN), SYNC_W, 1'b0);
      else if (r == 39) doReset();
      else applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] reset in the middle of traffic");
    sendBits(32'(SYNC_PATTERN), SYNC_W, 1'b0);
    sendBits(32'h5, 3, 1'b0);
    doReset();
    checkValue("midReset.cnt",  32'(frameCnt), 32'd0);
    checkValue("midReset.busy", 32'(busy),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
